// File: rtl/i2c_temp_poll_ctrl_if.sv
// Command/status bus between the temperature poll sequencer and I2C_Master.
//   master modport : sequencer side (drives go and command fields, reads status)
//   slave modport  : I2C_Master side
interface i2c_temp_poll_ctrl_if;
  logic       go;
  logic       rw;
  logic [5:0] N_Byte;
  logic [6:0] dev_add;
  logic [7:0] R_Pointer;
  logic [7:0] dwr_DataWriteReg;
  logic       done;
  logic       ready;
  logic [7:0] drd_lcdData;
  logic       ack_e;

  modport master (
    output go, rw, N_Byte, dev_add, R_Pointer, dwr_DataWriteReg,
    input  done, ready, drd_lcdData, ack_e
  );

  modport slave (
    input  go, rw, N_Byte, dev_add, R_Pointer, dwr_DataWriteReg,
    output done, ready, drd_lcdData, ack_e
  );
endinterface

// File: rtl/i2c_temp_poll_ctrl.sv
// Temperature sensor poll sequencer for I2C_Master.
// Issues a 2-byte read of TEMP_REG every POLL_CYCLES clocks, captures the
// bytes on the master's ready strobe and presents {MSB, LSB} on temp_data
// with a one-cycle temp_valid pulse. NACKs seen during a transaction are
// reported on nack_err; a master that never accepts go sets timeout_err.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   poll_en      : enables polling; block idles after current transaction when low
//   bus (master) : go/rw/N_Byte/dev_add/R_Pointer/dwr_DataWriteReg out,
//                  done/ready/drd_lcdData/ack_e in
//   temp_data    : last good reading {MSB, LSB}
//   temp_valid   : one-cycle pulse when temp_data updates
//   nack_err     : last transaction saw a NACK
//   timeout_err  : sticky, master failed to accept go in time
//
// Build option: TEMP_CFG_WRITE_EN -- one write of CFG_VAL to CFG_REG after
// reset, before polling starts.
module i2c_temp_poll_ctrl #(
  parameter int unsigned POLL_CYCLES = 50_000_000,
  parameter int unsigned ACC_TIMEOUT = 1_000_000,
  parameter logic [6:0]  DEV_ADDR    = 7'h48,
  parameter logic [7:0]  TEMP_REG    = 8'h00,
  parameter logic [7:0]  CFG_REG     = 8'h01,
  parameter logic [7:0]  CFG_VAL     = 8'h60
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        poll_en,
  i2c_temp_poll_ctrl_if.master        bus,
  output logic [15:0]                 temp_data,
  output logic                        temp_valid,
  output logic                        nack_err,
  output logic                        timeout_err
);

`ifdef TEMP_CFG_WRITE_EN
  localparam bit CFG_WRITE = 1'b1;
`else
  localparam bit CFG_WRITE = 1'b0;
`endif

  localparam logic [25:0] POLL_LAST = 26'(POLL_CYCLES - 1);
  localparam logic [19:0] TO_LAST   = 20'(ACC_TIMEOUT - 1);

  // CFG_* states are unreachable when CFG_WRITE is 0 and are pruned.
  typedef enum logic [3:0] {
    INIT, CFG_GO, CFG_ACPT, CFG_BUSY, POLL_WAIT,
    RD_GO, RD_ACPT, RD_BUSY, RD_DONE
  } state_t;

  state_t      state, state_n;
  logic [25:0] pcnt;
  logic [19:0] tcnt;
  logic [1:0]  idx;
  logic [7:0]  msb, lsb;
  logic        nack_lat;
  logic        poll_hit, to_hit, in_acpt;

  assign poll_hit = (pcnt == POLL_LAST);
  assign to_hit   = (tcnt == TO_LAST);
  assign in_acpt  = (state == CFG_ACPT) || (state == RD_ACPT);

  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      INIT:      if (bus.done) state_n = CFG_WRITE ? CFG_GO : POLL_WAIT;
      CFG_GO:    state_n = CFG_ACPT;
      CFG_ACPT:  if (!bus.done) state_n = CFG_BUSY;
                 else if (to_hit) state_n = POLL_WAIT;
      CFG_BUSY:  if (bus.done) state_n = POLL_WAIT;
      POLL_WAIT: if (poll_hit && poll_en) state_n = RD_GO;
      RD_GO:     state_n = RD_ACPT;
      RD_ACPT:   if (!bus.done) state_n = RD_BUSY;
                 else if (to_hit) state_n = POLL_WAIT;
      RD_BUSY:   if (bus.done) state_n = RD_DONE;
      RD_DONE:   state_n = POLL_WAIT;
      default:   state_n = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.go               <= 1'b0;
      bus.rw               <= 1'b0;
      bus.N_Byte           <= '0;
      bus.dev_add          <= DEV_ADDR;
      bus.R_Pointer        <= '0;
      bus.dwr_DataWriteReg <= '0;
      temp_data            <= '0;
      temp_valid           <= 1'b0;
      nack_err             <= 1'b0;
      timeout_err          <= 1'b0;
      pcnt                 <= '0;
      tcnt                 <= '0;
      idx                  <= '0;
      msb                  <= '0;
      lsb                  <= '0;
      nack_lat             <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      // Poll counter runs only in POLL_WAIT and parks at terminal count
      // while poll_en is low, so re-enabling starts a read immediately.
      pcnt <= (state == POLL_WAIT) ? (poll_hit ? pcnt : pcnt + 26'd1) : '0;
      tcnt <= in_acpt ? tcnt + 20'd1 : '0;

      case (state)
        CFG_GO: begin
          bus.rw               <= 1'b0;
          bus.N_Byte           <= 6'd1;
          bus.R_Pointer        <= CFG_REG;
          bus.dwr_DataWriteReg <= CFG_VAL;
          bus.go               <= 1'b1;
          nack_lat             <= 1'b0;
        end
        CFG_ACPT, RD_ACPT: begin
          if (!bus.done) begin
            bus.go <= 1'b0;
          end else if (to_hit) begin
            bus.go      <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        CFG_BUSY: begin
          nack_lat <= nack_lat | bus.ack_e;
          if (bus.done) nack_err <= nack_lat | bus.ack_e;
        end
        RD_GO: begin
          bus.rw        <= 1'b1;
          bus.N_Byte    <= 6'd2;
          bus.R_Pointer <= TEMP_REG;
          bus.go        <= 1'b1;
          idx           <= '0;
          nack_lat      <= 1'b0;
        end
        RD_BUSY: begin
          nack_lat <= nack_lat | bus.ack_e;
          if (bus.ready) begin
            if (idx == 2'd0) msb <= bus.drd_lcdData;
            if (idx == 2'd1) lsb <= bus.drd_lcdData;
            if (idx != 2'd2) idx <= idx + 2'd1;
          end
        end
        RD_DONE: begin
          nack_err <= nack_lat;
          if (!nack_lat && idx == 2'd2) begin
            temp_data  <= {msb, lsb};
            temp_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_temp_poll_ctrl.sv
module tb_i2c_temp_poll_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        poll_en;
  logic [15:0] temp_data;
  logic        temp_valid, nack_err, timeout_err;

  i2c_temp_poll_ctrl_if bus ();

  i2c_temp_poll_ctrl #(.POLL_CYCLES(100), .ACC_TIMEOUT(50)) dut (
    .clk         (clk),
    .reset       (reset),
    .poll_en     (poll_en),
    .bus         (bus),
    .temp_data   (temp_data),
    .temp_valid  (temp_valid),
    .nack_err    (nack_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;
  int cyc = 0, done_cyc = 0;
  int vcount = 0, exp_vcount = 0, vrun = 0, vrun_max = 0;
  logic [15:0] m_temp = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (temp_valid === 1'b1) begin
      vcount = vcount + 1;
      vrun   = vrun + 1;
      if (vrun > vrun_max) vrun_max = vrun;
    end else begin
      vrun = 0;
    end
  end

  typedef struct {
    int         n;
    logic [7:0] d0, d1, d2;
    bit         nk;
    bit         same;
    bit         ev;
    logic [15:0] et;
    bit         en;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_go"},   bus.go, 0);
    chk({tag, "_rw"},   bus.rw, 0);
    chk({tag, "_nb"},   bus.N_Byte, 0);
    chk({tag, "_dev"},  bus.dev_add, 7'h48);
    chk({tag, "_ptr"},  bus.R_Pointer, 0);
    chk({tag, "_dwr"},  bus.dwr_DataWriteReg, 0);
    chk({tag, "_temp"}, temp_data, 0);
    chk({tag, "_val"},  temp_valid, 0);
    chk({tag, "_nack"}, nack_err, 0);
    chk({tag, "_to"},   timeout_err, 0);
  endtask

  task automatic wait_go(input bit chk_period);
    int t = 0;
    while (bus.go !== 1'b1 && t < 400) begin tick(); t++; end
    chk("go_rise", bus.go, 1);
    if (chk_period) chk("period", cyc - done_cyc, 103);
  endtask

  // Behavioural master: accept go, optional NACK, n byte strobes, then done.
  task automatic run_txn(input int n, input logic [7:0] d0, d1, d2, input bit nk,
                         input bit same, input bit ev, input logic [15:0] et,
                         input bit en, input bit chk_period, input bit drop_en);
    logic [7:0] b [3];
    b[0] = d0; b[1] = d1; b[2] = d2;
    wait_go(chk_period);
    if (drop_en) poll_en = 1'b0;
    chk("rd_rw",  bus.rw, 1);
    chk("rd_nb",  bus.N_Byte, 2);
    chk("rd_ptr", bus.R_Pointer, 8'h00);
    chk("rd_dev", bus.dev_add, 7'h48);
    tick();
    bus.done = 1'b0;
    tick();
    chk("go_drop", bus.go, 0);
    if (nk) begin bus.ack_e = 1'b1; tick(); bus.ack_e = 1'b0; end
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 3)) tick();
      bus.drd_lcdData = b[i];
      bus.ready = 1'b1;
      if (same && i == n - 1) begin bus.done = 1'b1; done_cyc = cyc; end
      tick();
      bus.ready = 1'b0;
      bus.drd_lcdData = 8'($urandom);
    end
    if (!(same && n > 0)) begin
      repeat ($urandom_range(0, 2)) tick();
      bus.done = 1'b1;
      done_cyc = cyc;
      tick();
    end
    tick();
    chk("valid", temp_valid, ev);
    chk("temp", temp_data, et);
    chk("nack", nack_err, en);
    if (ev) exp_vcount++;
    tick();
    chk("valid_1cyc", temp_valid, 0);
  endtask

  // Reference rule: a reading is taken from the first two bytes of an
  // un-NACKed read that delivered at least two bytes.
  function automatic bit model(input int n, input logic [7:0] d0, d1, input bit nk);
    if (!nk && n >= 2) begin
      m_temp = {d0, d1};
      return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    int t;
    bit ev;
    int n;
    logic [7:0] r0, r1, r2;
    bit nk, same;

    tbl[0] = '{2, 8'h19, 8'h80, 8'h00, 0, 0, 1, 16'h1980, 0};
    tbl[1] = '{2, 8'hAA, 8'hBB, 8'h00, 1, 0, 0, 16'h1980, 1};
    tbl[2] = '{3, 8'h11, 8'h22, 8'h33, 0, 0, 1, 16'h1122, 0};
    tbl[3] = '{1, 8'h55, 8'h00, 8'h00, 0, 0, 0, 16'h1122, 0};
    tbl[4] = '{2, 8'hAB, 8'hCD, 8'h00, 0, 1, 1, 16'hABCD, 0};
    tbl[5] = '{0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 16'hABCD, 1};
    tbl[6] = '{2, 8'h12, 8'h34, 8'h00, 0, 1, 1, 16'h1234, 0};

    reset = 1'b1; poll_en = 1'b1;
    bus.done = 1'b1; bus.ready = 1'b0; bus.ack_e = 1'b0; bus.drd_lcdData = 8'h00;
    repeat (3) tick();
    chk_reset("rst");
    reset = 1'b0;

`ifdef TEMP_CFG_WRITE_EN
    wait_go(0);
    chk("cfg_rw",  bus.rw, 0);
    chk("cfg_nb",  bus.N_Byte, 1);
    chk("cfg_ptr", bus.R_Pointer, 8'h01);
    chk("cfg_dwr", bus.dwr_DataWriteReg, 8'h60);
    tick();
    bus.done = 1'b0;
    repeat (4) tick();
    bus.done = 1'b1;
    repeat (2) tick();
    chk("cfg_nack", nack_err, 0);
`endif

    foreach (tbl[i]) begin
      ev = model(tbl[i].n, tbl[i].d0, tbl[i].d1, tbl[i].nk);
      run_txn(tbl[i].n, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].nk, tbl[i].same,
              tbl[i].ev, tbl[i].et, tbl[i].en, i > 0, 0);
    end

    for (int k = 0; k < 12; k++) begin
      n    = $urandom_range(0, 3);
      r0   = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
      nk   = ($urandom_range(0, 3) == 0);
      same = (n > 0) && ($urandom_range(0, 1) == 1);
      ev   = model(n, r0, r1, nk);
      run_txn(n, r0, r1, r2, nk, same, ev, m_temp, nk, 1, 0);
    end

    // Accept timeout: done never falls.
    wait_go(1);
    chk("to_pre", timeout_err, 0);
    t = 0;
    while (bus.go === 1'b1 && t < 200) begin tick(); t++; end
    chk("to_go_width", t, 50);
    chk("to_err", timeout_err, 1);
    t = 0;
    while (bus.go !== 1'b1 && t < 300) begin tick(); t++; end
    chk("to_resume", t, 101);
    r0 = 8'($urandom); r1 = 8'($urandom);
    ev = model(2, r0, r1, 0);
    run_txn(2, r0, r1, 8'h00, 0, 0, ev, m_temp, 0, 0, 0);
    chk("to_sticky", timeout_err, 1);

    // poll_en dropped mid-transaction: finishes, then idles.
    r0 = 8'($urandom); r1 = 8'($urandom);
    ev = model(2, r0, r1, 0);
    run_txn(2, r0, r1, 8'h00, 0, 0, ev, m_temp, 0, 1, 1);
    t = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (bus.go === 1'b1) t++;
    end
    chk("idle_no_go", t, 0);
    poll_en = 1'b1;
    t = 0;
    while (bus.go !== 1'b1 && t < 10) begin tick(); t++; end
    chk("reenable_go", t, 2);

    // Reset between the two byte strobes.
    tick();
    bus.done = 1'b0;
    tick();
    bus.drd_lcdData = 8'h77; bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk_reset("midrst");
    reset = 1'b0;
    bus.done = 1'b1;
    repeat (20) tick();

    chk("valid_count", vcount, exp_vcount);
    chk("valid_width", vrun_max, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
